exe_muldiv: RTL



---
 rtl/exe_muldiv.sv | 108 ++++++++++
 1 files changed

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies take one cycle in MUL; divides run a 32-step restoring loop then a sign fix-up.
module exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, result_q, result_d;
  logic accept, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, dvs, spec_res, fix_q, fix_r;
  logic [XLEN:0] shifted, diff;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign accept   = state_q == IDLE && start_i && !flush_i;
  assign div_zero = rs2_i == '0;
  assign div_ovf  = !op_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && &rs2_i;
  assign spec_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
  assign abs_a    = (!op_i[0] && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign dvs      = (!op_q[0] && b_q[XLEN-1]) ? -b_q : b_q;
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs};
  // Sign-extending to 64 bits lets one unsigned multiply cover all three signedness modes.
  assign a_ext    = {{XLEN{op_q[1:0] != 2'b11 && a_q[XLEN-1]}}, a_q};
  assign b_ext    = {{XLEN{!op_q[1] && b_q[XLEN-1]}}, b_q};
  assign prod     = a_ext * b_ext;
  assign fix_q    = (!op_q[0] && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
  assign fix_r    = (!op_q[0] && a_q[XLEN-1]) ? -rem_q : rem_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_d    = op_i;
          a_d     = rs1_i;
          b_d     = rs2_i;
          rem_d   = '0;
          quo_d   = abs_a;
          cnt_d   = '0;
          state_d = !op_i[2] ? MUL : (div_zero || div_ovf) ? DONE : DIV;
          if (op_i[2] && (div_zero || div_ovf)) result_d = spec_res;
        end
        MUL: begin
          result_d = op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
        DIV: begin
          rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo_d   = {quo_q[XLEN-2:0], !diff[XLEN]};
          cnt_d   = cnt_q + 5'd1;
          state_d = cnt_q == 5'd31 ? FIX : DIV;
        end
        FIX: begin
          result_d = op_q[1] ? fix_r : fix_q;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end
  assign stall_req_o = accept || state_q == MUL || state_q == DIV || state_q == FIX;
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign result_o    = result_q;
endmodule
